// File: rtl/kronos_store_buffer.sv
// Posted-store buffer between EX and the data bus: queues stores, lets loads
// bypass when no word-address hazard exists, and drains on fence.
module kronos_store_buffer #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned LOAD_PRIORITY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    st_vld,
  output logic                    st_rdy,
  input  logic [31:0]             st_addr,
  input  logic [31:0]             st_data,
  input  logic [3:0]              st_mask,
  input  logic                    ld_vld,
  input  logic [31:0]             ld_addr,
  input  logic [3:0]              ld_mask,
  output logic                    ld_rdy,
  output logic [31:0]             ld_data,
  input  logic                    fence_vld,
  output logic                    fence_rdy,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic [31:0]             data_addr,
  output logic [31:0]             data_wr_data,
  output logic [3:0]              data_mask,
  output logic                    data_wr_en,
  output logic                    data_req,
  input  logic [31:0]             data_rd_data,
  input  logic                    data_ack
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, STORE, LOAD} state_t;

  state_t          state_q;
  logic [31:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [3:0]      mask_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     data_addr_q, data_wr_data_q;
  logic [3:0]      data_mask_q;
  logic            data_wr_en_q, data_req_q, fence_rdy_q;
  logic            push, pop, hazard, load_go, store_go;

  assign st_rdy  = count_q < CW'(DEPTH);
  assign push    = st_vld && st_rdy;
  assign pop     = (state_q == STORE) && data_ack && !rst;
  assign ld_rdy  = (state_q == LOAD) && data_ack && !rst;
  assign ld_data = ld_rdy ? data_rd_data : '0;
  assign empty   = (count_q == '0);
  assign count   = count_q;

  assign data_addr    = data_addr_q;
  assign data_wr_data = data_wr_data_q;
  assign data_mask    = data_mask_q;
  assign data_wr_en   = data_wr_en_q;
  assign data_req     = data_req_q;
  assign fence_rdy    = fence_rdy_q;

  // Word-granular match against buffered entries and a store entering this cycle.
  always_comb begin
    hazard = push && (st_addr[31:2] == ld_addr[31:2]);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i][31:2] == ld_addr[31:2])) hazard = 1'b1;
    end
  end

  assign load_go  = (state_q == IDLE) && ld_vld && !fence_vld && !hazard &&
                    ((LOAD_PRIORITY != 0) || empty);
  assign store_go = (state_q == IDLE) && !empty && !load_go;

  always_comb begin
    vld_d = vld_q;
    if (pop)  vld_d[head_q] = 1'b0;
    if (push) vld_d[tail_q] = 1'b1;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
      mask_q[tail_q] <= st_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      vld_q          <= '0;
      data_addr_q    <= '0;
      data_wr_data_q <= '0;
      data_mask_q    <= '0;
      data_wr_en_q   <= 1'b0;
      data_req_q     <= 1'b0;
      fence_rdy_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      vld_q   <= vld_d;
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      // Self-clearing so a requester that holds fence_vld one extra cycle sees a single pulse.
      fence_rdy_q <= fence_vld && empty && (state_q == IDLE) && !push && !fence_rdy_q;
      case (state_q)
        IDLE: begin
          if (load_go) begin
            state_q        <= LOAD;
            data_req_q     <= 1'b1;
            data_addr_q    <= ld_addr;
            data_mask_q    <= ld_mask;
            data_wr_data_q <= '0;
            data_wr_en_q   <= 1'b0;
          end else if (store_go) begin
            state_q        <= STORE;
            data_req_q     <= 1'b1;
            data_addr_q    <= addr_q[head_q];
            data_wr_data_q <= data_q[head_q];
            data_mask_q    <= mask_q[head_q];
            data_wr_en_q   <= 1'b1;
          end
        end
        STORE, LOAD: begin
          if (data_ack) begin
            state_q      <= IDLE;
            data_req_q   <= 1'b0;
            data_wr_en_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kronos_store_buffer.sv
// Directed bench for kronos_store_buffer: one instance with load priority,
// one with store priority; bus transactions are checked against a scoreboard.
module tb_kronos_store_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst, st_vld, ld_vld, fence_vld;
  logic [31:0] st_addr, st_data, ld_addr;
  logic [3:0]  st_mask, ld_mask;

  logic        strdy [2];
  logic        ldrdy [2];
  logic [31:0] lddata[2];
  logic        frdy  [2];
  logic [2:0]  cnt   [2];
  logic        emp   [2];
  logic [31:0] daddr [2];
  logic [31:0] dwdata[2];
  logic [3:0]  dmask [2];
  logic        dwen  [2];
  logic        dreq  [2];
  logic [31:0] rdd   [2];
  logic        ack   [2];

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } txn_t;

  txn_t        sbq[$];
  logic [31:0] ldq[$];

  kronos_store_buffer #(.DEPTH(4), .LOAD_PRIORITY(1)) u_lp1 (
    .clk(clk), .rst(rst),
    .st_vld(st_vld), .st_rdy(strdy[0]), .st_addr(st_addr), .st_data(st_data), .st_mask(st_mask),
    .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_mask(ld_mask), .ld_rdy(ldrdy[0]), .ld_data(lddata[0]),
    .fence_vld(fence_vld), .fence_rdy(frdy[0]), .count(cnt[0]), .empty(emp[0]),
    .data_addr(daddr[0]), .data_wr_data(dwdata[0]), .data_mask(dmask[0]), .data_wr_en(dwen[0]),
    .data_req(dreq[0]), .data_rd_data(rdd[0]), .data_ack(ack[0])
  );

  kronos_store_buffer #(.DEPTH(4), .LOAD_PRIORITY(0)) u_lp0 (
    .clk(clk), .rst(rst),
    .st_vld(st_vld), .st_rdy(strdy[1]), .st_addr(st_addr), .st_data(st_data), .st_mask(st_mask),
    .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_mask(ld_mask), .ld_rdy(ldrdy[1]), .ld_data(lddata[1]),
    .fence_vld(fence_vld), .fence_rdy(frdy[1]), .count(cnt[1]), .empty(emp[1]),
    .data_addr(daddr[1]), .data_wr_data(dwdata[1]), .data_mask(dmask[1]), .data_wr_en(dwen[1]),
    .data_req(dreq[1]), .data_rd_data(rdd[1]), .data_ack(ack[1])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic store(input int s, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic exp_rdy);
    st_vld  = 1'b1;
    st_addr = a;
    st_data = d;
    st_mask = m;
    #1;
    chk("st_rdy", strdy[s], exp_rdy);
    if (exp_rdy) sbq.push_back('{we: 1'b1, addr: a, data: d, mask: m});
    tick;
    st_vld = 1'b0;
  endtask

  task automatic wait_req(input int s, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (dreq[s] === 1'b1) break;
      tick;
    end
    chk("data_req_seen", dreq[s], 1'b1);
  endtask

  task automatic drain(input int s, input int n);
    txn_t        e;
    logic [31:0] rv;
    for (int t = 0; t < n; t++) begin
      wait_req(s, 40);
      if (sbq.size() == 0) begin
        chk("unexpected_req", dreq[s], 1'b0);
        e = '0;
      end else begin
        e = sbq.pop_front();
        chk("bus_addr", daddr[s], e.addr);
        chk("bus_wr_en", dwen[s], e.we);
        chk("bus_mask", dmask[s], e.mask);
        if (e.we) chk("bus_wr_data", dwdata[s], e.data);
      end
      ack[s] = 1'b1;
      rv = 32'hD00D_0000 ^ e.addr;
      rdd[s] = rv;
      if (!e.we) ldq.push_back(rv);
      #1;
      chk("ld_rdy", ldrdy[s], !e.we);
      if (!e.we && ldq.size() > 0) chk("ld_data", lddata[s], ldq.pop_front());
      tick;
      ack[s] = 1'b0;
      if (!e.we) ld_vld = 1'b0;
      chk("idle_gap", dreq[s], 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; st_vld = 1'b0; ld_vld = 1'b0; fence_vld = 1'b0;
    st_addr = '0; st_data = '0; st_mask = '0; ld_addr = '0; ld_mask = '0;
    ack[0] = 1'b0; ack[1] = 1'b0; rdd[0] = '0; rdd[1] = '0;
    repeat (2) tick;
    chk("rst_count", cnt[0], 0);
    chk("rst_empty", emp[0], 1);
    chk("rst_req", dreq[0], 0);
    chk("rst_wr_en", dwen[0], 0);
    chk("rst_ld_rdy", ldrdy[0], 0);
    chk("rst_fence_rdy", frdy[0], 0);
    chk("rst_st_rdy", strdy[0], 1);
    chk("rst_req_lp0", dreq[1], 0);
    rst = 1'b0;
    tick;

    // Fill to full with the bus stalled; fifth store is refused.
    for (int i = 0; i < 5; i++) begin
      st_vld  = 1'b1;
      st_addr = 32'h1000 + 32'(i * 16);
      st_data = 32'hA000_0000 + 32'(i);
      st_mask = 4'hF ^ 4'(i);
      #1;
      chk("fill_st_rdy", strdy[0], (i < 4));
      if (i < 4) sbq.push_back('{we: 1'b1, addr: st_addr, data: st_data, mask: st_mask});
      if (i == 1) chk("st_lat_n1", dreq[0], 0);
      if (i == 2) chk("st_lat_n2", dreq[0], 1);
      if (i == 4) chk("full_count", cnt[0], 4);
      tick;
    end
    st_vld = 1'b0;
    drain(0, 1);
    chk("pop_count", cnt[0], 3);
    chk("pop_st_rdy", strdy[0], 1);
    store(0, 32'h2000, 32'h5555_AAAA, 4'h5, 1'b1);
    drain(0, 4);
    chk("wrap_count", cnt[0], 0);
    chk("wrap_empty", emp[0], 1);

    // Load hits a buffered store's word: store must drain first.
    store(0, 32'h100, 32'h1111_1111, 4'hF, 1'b1);
    ld_vld = 1'b1; ld_addr = 32'h102; ld_mask = 4'b1100;
    sbq.push_back('{we: 1'b0, addr: 32'h102, data: '0, mask: 4'b1100});
    drain(0, 2);

    // Load hits a store pushed in the same cycle.
    ld_vld = 1'b1; ld_addr = 32'h300; ld_mask = 4'hF;
    store(0, 32'h300, 32'h3030_3030, 4'hF, 1'b1);
    sbq.push_back('{we: 1'b0, addr: 32'h300, data: '0, mask: 4'hF});
    drain(0, 2);

    // Load priority: non-hazard load bypasses the buffered store; stray ack in IDLE ignored.
    store(0, 32'h100, 32'h2222_2222, 4'h3, 1'b1);
    ld_vld = 1'b1; ld_addr = 32'h200; ld_mask = 4'hF;
    ack[0] = 1'b1;
    sbq.push_front('{we: 1'b0, addr: 32'h200, data: '0, mask: 4'hF});
    tick;
    ack[0] = 1'b0;
    chk("ld_lat_req", dreq[0], 1);
    chk("ld_first_wr_en", dwen[0], 0);
    chk("idle_ack_ignored", cnt[0], 1);
    drain(0, 2);

    // Store priority instance: store goes before the load.
    rst = 1'b1; tick; rst = 1'b0; sbq.delete();
    store(1, 32'h100, 32'h3333_3333, 4'hF, 1'b1);
    ld_vld = 1'b1; ld_addr = 32'h200; ld_mask = 4'hF;
    sbq.push_back('{we: 1'b0, addr: 32'h200, data: '0, mask: 4'hF});
    drain(1, 2);

    // Fence after three stores.
    rst = 1'b1; ld_vld = 1'b0; tick; rst = 1'b0; sbq.delete();
    store(0, 32'h400, 32'h4000_0000, 4'hF, 1'b1);
    store(0, 32'h404, 32'h4000_0004, 4'hF, 1'b1);
    store(0, 32'h408, 32'h4000_0008, 4'hF, 1'b1);
    fence_vld = 1'b1;
    drain(0, 3);
    chk("fence_early", frdy[0], 0);
    tick;
    chk("fence_pulse", frdy[0], 1);
    chk("fence_count", cnt[0], 0);
    fence_vld = 1'b0;
    tick;
    chk("fence_once", frdy[0], 0);

    // Reset during a store with two entries buffered.
    store(0, 32'h500, 32'h5000_0000, 4'hF, 1'b1);
    store(0, 32'h504, 32'h5000_0004, 4'hF, 1'b1);
    wait_req(0, 10);
    chk("pre_rst_count", cnt[0], 2);
    rst = 1'b1; ack[0] = 1'b1;
    tick;
    rst = 1'b0; ack[0] = 1'b0; sbq.delete();
    chk("rst_mid_req", dreq[0], 0);
    chk("rst_mid_count", cnt[0], 0);
    chk("rst_mid_empty", emp[0], 1);

    // Reset during a load: no ld_rdy even with ack.
    ld_vld = 1'b1; ld_addr = 32'h600; ld_mask = 4'hF;
    tick;
    wait_req(0, 10);
    rst = 1'b1; ack[0] = 1'b1;
    #1;
    chk("rst_ld_rdy_mid", ldrdy[0], 0);
    tick;
    rst = 1'b0; ack[0] = 1'b0; ld_vld = 1'b0;
    chk("rst_ld_req", dreq[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kronos_store_buffer.md
KRONOS_STORE_BUFFER -- requirements
Module: kronos_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of posted-store entries; legal values are powers of 2 from 2 to 16.
REQ-002 SHALL have parameter LOAD_PRIORITY, default 1; when 1, loads may bypass buffered stores; when 0, stores drain first.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 st_vld  in  1  store request from EX.
REQ-007 st_rdy  out  1  store accepted this cycle; combinational, equal to count < DEPTH.
REQ-008 st_addr / st_data / st_mask  in  32/32/4  store address, aligned write data, byte enables.
REQ-009 ld_vld  in  1  load request from EX.
REQ-010 ld_addr / ld_mask  in  32/4  load address and byte enables.
REQ-011 ld_rdy  out  1  load complete, one-cycle pulse.
REQ-012 ld_data  out  32  load data, valid only while ld_rdy is high.
REQ-013 fence_vld / fence_rdy  in/out  1/1  drain request and completion pulse.
REQ-014 count  out  $clog2(DEPTH)+1  number of occupied entries; empty  out  1  high when count==0.
REQ-015 data_addr / data_wr_data / data_mask / data_wr_en / data_req  out  32/32/4/1/1  data bus request; data_rd_data / data_ack  in  32/1.

Function
REQ-016 Store push: on st_vld&&st_rdy, write {addr,data,mask} at the tail and advance the tail pointer modulo DEPTH.
REQ-017 Simultaneous push and pop: count is unchanged; st_rdy stays 0 when full even if a pop occurs that cycle, so there is no pass-through.
REQ-018 Bus FSM states: IDLE, STORE, LOAD; data_req is registered and is high exactly in STORE and LOAD.
REQ-019 IDLE->LOAD: ld_vld high, no hazard, and (LOAD_PRIORITY==1 or empty); a load wins over a pending store in the same cycle.
REQ-020 IDLE->STORE: count>0 and the IDLE->LOAD condition is false.
REQ-021 Hazard: any occupied entry, or a store pushed in the same cycle, with addr[31:2]==ld_addr[31:2]; comparison is word-granular and ignores masks.
REQ-022 On entry to LOAD: latch data_addr=ld_addr, data_mask=ld_mask, data_wr_en=0.
REQ-023 On entry to STORE: latch the head entry fields and set data_wr_en=1.
REQ-024 Bus outputs SHALL be held stable until data_ack.
REQ-025 LOAD with data_ack: ld_rdy=1 and ld_data=data_rd_data, both combinational in the same cycle; the FSM then returns to IDLE.
REQ-026 STORE with data_ack: pop the head, advancing the head pointer modulo DEPTH; the FSM then returns to IDLE.
REQ-027 Latency: a store accepted in cycle N gives data_req no earlier than N+2; a hazard-free load presented in IDLE at cycle N gives data_req at N+1.
REQ-028 Every bus transaction is followed by at least one IDLE cycle.
REQ-029 ld_vld and the ld_* inputs SHALL be held until ld_rdy; a hazarded load waits in IDLE while the stores drain.
REQ-030 fence_rdy pulses for one cycle when fence_vld is high, count==0, the FSM is in IDLE, and no push occurs that cycle.
REQ-031 While fence_vld is high, no load is issued.
REQ-032 data_ack outside STORE/LOAD SHALL be ignored.

Reset
REQ-033 On rst: state=IDLE, head/tail/count=0, empty=1, data_req=0, data_wr_en=0, ld_rdy=0, fence_rdy=0.
REQ-034 Buffered stores SHALL be discarded on rst.
REQ-035 Reset mid-transaction drops data_req the next cycle with no pop and no ld_rdy.

Verification
REQ-036 DEPTH=4: push 5 stores with data_ack held low -> st_rdy=0 after the 4th push, count=4.
REQ-037 Continue REQ-036: ack the first store -> pop, count=3, st_rdy=1; pointers wrap through index 0.
REQ-038 Buffer store to 0x100, then ld_vld to 0x102 -> no load data_req until the 0x100 store is acked; then a load issues with data_addr=0x102.
REQ-039 Buffer store to 0x100, then load 0x200 with LOAD_PRIORITY=1 -> load issues first, ld_rdy with ld_data=data_rd_data.
REQ-040 Repeat REQ-039 with LOAD_PRIORITY=0 -> store issues first.
REQ-041 Buffer 3 stores, assert fence_vld -> fence_rdy pulses once, exactly one cycle after the IDLE cycle following the 3rd ack, with count=0.
REQ-042 Assert rst during STORE with 2 entries -> next cycle data_req=0, count=0, empty=1.
